// File: rtl/palette_stream_decoder_pkg.sv
// Shared constants and constant-evaluated helpers for the palette stream decoder.
// Digit extraction uses compare/subtract against constant multiples, never a generic divider.
package palette_stream_decoder_pkg;

  localparam int unsigned MAX_LEVELS = 4;
  localparam int unsigned DIG_W      = 2;

  function automatic int unsigned cube_size(input int unsigned levels);
    return levels * levels * levels;
  endfunction

  function automatic int unsigned pix_w(input int unsigned r_w, input int unsigned g_w,
                                        input int unsigned b_w);
    return r_w + g_w + b_w;
  endfunction

  // Quotient of value by unit, assuming value < levels*unit; saturates at levels-1 otherwise.
  function automatic int unsigned digit_of(input int unsigned value, input int unsigned unit,
                                           input int unsigned levels);
    int unsigned q;
    q = 0;
    for (int unsigned k = 1; k < MAX_LEVELS; k++) begin
      if (k < levels && value >= k * unit) q = k;
    end
    return q;
  endfunction

endpackage

// File: rtl/palette_stream_decoder_channel_level_scale.sv
// Combinational digit -> channel intensity: floor(d * (2**W - 1) / (LEVELS - 1)).
// Each case is a constant, so no arithmetic survives into the netlist.
module channel_level_scale
  import palette_stream_decoder_pkg::*;
#(
  parameter int unsigned LEVELS = 3,
  parameter int unsigned W      = 3
) (
  input  logic [DIG_W-1:0] digit,
  output logic [W-1:0]     level
);

  always_comb begin
    level = '0;
    for (int unsigned k = 0; k < LEVELS; k++) begin
      if (32'(digit) == k) level = W'((k * ((2 ** W) - 1)) / (LEVELS - 1));
    end
  end

endmodule

// File: rtl/palette_stream_decoder.sv
// Two-stage valid/ready palette index -> RGB decoder (cube palette, LEVELS per channel).
// Define PALETTE_WR_EN to add a run-time override RAM with per-entry override flags.
module palette_stream_decoder
  import palette_stream_decoder_pkg::*;
#(
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned LEVELS = 3,
  parameter int unsigned R_W    = 3,
  parameter int unsigned G_W    = 3,
  parameter int unsigned B_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDX_W-1:0]       in_idx,
  input  logic                   in_blank,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [R_W-1:0]         rouge,
  output logic [G_W-1:0]         vert,
  output logic [B_W-1:0]         bleu,
  input  logic                   pal_we,
  input  logic [IDX_W-1:0]       pal_addr,
  input  logic [R_W+G_W+B_W-1:0] pal_data
);

  localparam int unsigned CUBE_SIZE = cube_size(LEVELS);
  localparam int unsigned PIX_W     = pix_w(R_W, G_W, B_W);
  localparam int unsigned PLANE     = LEVELS * LEVELS;

  logic             s2_take;
  logic             s1_load;
  logic [31:0]      idx_u;
  logic [31:0]      rem_u;
  logic [DIG_W-1:0] r_d, g_d, b_d;
  logic             black_d;

  logic             s1_valid;
  logic [DIG_W-1:0] s1_r, s1_g, s1_b;
  logic             s1_black;

  logic [R_W-1:0]   r_lvl, r_nxt;
  logic [G_W-1:0]   g_lvl, g_nxt;
  logic [B_W-1:0]   b_lvl, b_nxt;

  // Output register frees when empty or draining; stage 1 frees when empty or handing off.
  assign s2_take  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_take;
  assign s1_load  = in_valid && in_ready;

  // Digit split: r = idx / L^2, then g/b from the remainder.
  always_comb begin
    idx_u = 32'(in_idx);
    r_d   = DIG_W'(digit_of(idx_u, PLANE, LEVELS));
    rem_u = idx_u - 32'(r_d) * PLANE;
    g_d   = DIG_W'(digit_of(rem_u, LEVELS, LEVELS));
    b_d   = DIG_W'(rem_u - 32'(g_d) * LEVELS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_black <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_r     <= r_d;
      s1_g     <= g_d;
      s1_b     <= b_d;
      s1_black <= black_d;
    end else if (s2_take) begin
      s1_valid <= 1'b0;
    end
  end

  channel_level_scale #(
    .LEVELS(LEVELS),
    .W     (R_W)
  ) u_scale_r (
    .digit(s1_r),
    .level(r_lvl)
  );

  channel_level_scale #(
    .LEVELS(LEVELS),
    .W     (G_W)
  ) u_scale_g (
    .digit(s1_g),
    .level(g_lvl)
  );

  channel_level_scale #(
    .LEVELS(LEVELS),
    .W     (B_W)
  ) u_scale_b (
    .digit(s1_b),
    .level(b_lvl)
  );

`ifdef PALETTE_WR_EN
  localparam int unsigned ENTRIES = 2 ** IDX_W;

  logic [PIX_W-1:0]   pal_mem [ENTRIES];
  logic [ENTRIES-1:0] pal_flag;
  logic               s1_ovr;
  logic [PIX_W-1:0]   s1_pix;

  always_ff @(posedge clk) begin
    if (pal_we) pal_mem[pal_addr] <= pal_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pal_flag <= '0;
    end else if (pal_we) begin
      pal_flag[pal_addr] <= 1'b1;
    end
  end

  // Read happens on the accept edge, so a same-edge write is not yet visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_ovr <= 1'b0;
      s1_pix <= '0;
    end else if (s1_load) begin
      s1_ovr <= pal_flag[in_idx];
      s1_pix <= pal_mem[in_idx];
    end
  end

  // An overridden entry is valid even above the cube range; blanking still wins.
  assign black_d = in_blank || (!pal_flag[in_idx] && idx_u >= CUBE_SIZE);

  always_comb begin
    if (s1_black) begin
      r_nxt = '0;
      g_nxt = '0;
      b_nxt = '0;
    end else if (s1_ovr) begin
      {r_nxt, g_nxt, b_nxt} = s1_pix;
    end else begin
      r_nxt = r_lvl;
      g_nxt = g_lvl;
      b_nxt = b_lvl;
    end
  end
`else
  logic pal_unused;
  assign pal_unused = ^{pal_we, pal_addr, pal_data};

  assign black_d = in_blank || (idx_u >= CUBE_SIZE);

  always_comb begin
    if (s1_black) begin
      r_nxt = '0;
      g_nxt = '0;
      b_nxt = '0;
    end else begin
      r_nxt = r_lvl;
      g_nxt = g_lvl;
      b_nxt = b_lvl;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      rouge     <= '0;
      vert      <= '0;
      bleu      <= '0;
    end else if (s2_take) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        rouge <= r_nxt;
        vert  <= g_nxt;
        bleu  <= b_nxt;
      end
    end
  end

endmodule

// File: tb/tb_palette_stream_decoder.sv
// Self-checking bench for palette_stream_decoder (default and LEVELS=4 instances).
// Override checks are compiled in when PALETTE_WR_EN is defined.
module tb_palette_stream_decoder;

`ifdef PALETTE_WR_EN
  localparam bit PAL_EN = 1'b1;
`else
  localparam bit PAL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_blank, out_valid, out_ready, pal_we;
  logic [4:0] in_idx, pal_addr;
  logic [7:0] pal_data;
  logic [2:0] rouge, vert;
  logic [1:0] bleu;

  logic       v4, rdy4, ov4;
  logic [5:0] idx4;
  logic [2:0] r4, g4;
  logic [1:0] b4;

  always #5 clk = ~clk;

  palette_stream_decoder #(
    .IDX_W(5), .LEVELS(3), .R_W(3), .G_W(3), .B_W(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .in_blank(in_blank), .out_valid(out_valid), .out_ready(out_ready), .rouge(rouge),
    .vert(vert), .bleu(bleu), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data)
  );

  palette_stream_decoder #(
    .IDX_W(6), .LEVELS(4), .R_W(3), .G_W(3), .B_W(2)
  ) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_idx(idx4),
    .in_blank(1'b0), .out_valid(ov4), .out_ready(1'b1), .rouge(r4),
    .vert(g4), .bleu(b4), .pal_we(1'b0), .pal_addr(6'd0), .pal_data(8'd0)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] expq[$];
  logic [7:0] exp4q[$];
  int         accq[$];
  bit         lat_chk = 1'b0;
  bit         ovr_flag[32];
  logic [7:0] ovr_val[32];
  bit         stall_prev = 1'b0;
  logic [7:0] prev_rgb;
  bit         saw_bp;
  bit         dummy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Spec-level model: base-LEVELS digits, each scaled to full range with plain arithmetic.
  function automatic logic [7:0] model(input int idx, input bit blank, input int lv);
    int r, g, b;
    if (blank || idx >= lv * lv * lv) return 8'h00;
    r = (idx / (lv * lv)) * 7 / (lv - 1);
    g = ((idx / lv) % lv) * 7 / (lv - 1);
    b = (idx % lv) * 3 / (lv - 1);
    return {r[2:0], g[2:0], b[1:0]};
  endfunction

  // One clock: sample at the falling edge, score, then move to just past the next rising edge.
  task automatic tick(input bit use_const, input logic [7:0] cval, output bit acc);
    logic [7:0] e;
    int         a;
    @(negedge clk);
    cyc++;
    acc = in_valid && in_ready;
    if (stall_prev) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_rgb", 32'({rouge, vert, bleu}), 32'(prev_rgb));
    end
    if (!in_ready) saw_bp = 1'b1;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = expq.pop_front();
        a = accq.pop_front();
        check("pixel", 32'({rouge, vert, bleu}), 32'(e));
        if (lat_chk) check("latency", 32'(cyc - a), 32'd2);
      end
    end
    if (acc) begin
      e = model(int'(in_idx), in_blank, 3);
      if (!in_blank && ovr_flag[in_idx]) e = ovr_val[in_idx];
      if (use_const) e = cval;
      expq.push_back(e);
      accq.push_back(cyc);
    end
    if (PAL_EN && pal_we) begin
      ovr_flag[pal_addr] = 1'b1;
      ovr_val[pal_addr]  = pal_data;
    end
    if (ov4) begin
      if (exp4q.size() == 0) check("spurious_out_l4", 32'(ov4), 32'd0);
      else check("pixel_l4", 32'({r4, g4, b4}), 32'(exp4q.pop_front()));
    end
    if (v4 && rdy4) exp4q.push_back(model(int'(idx4), 1'b0, 4));
    stall_prev = out_valid && !out_ready;
    prev_rgb   = {rouge, vert, bleu};
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    v4        = 1'b0;
    pal_we    = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (expq.size() != 0 || exp4q.size() != 0); i++) tick(0, 8'h0, dummy);
    check("drain", 32'(expq.size() + exp4q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    v4       = 1'b0;
    pal_we   = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rgb", 32'({rouge, vert, bleu}), 32'd0);
    check("rst_out_valid_l4", 32'(ov4), 32'd0);
    expq.delete();
    exp4q.delete();
    accq.delete();
    for (int i = 0; i < 32; i++) ovr_flag[i] = 1'b0;
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_idx    = '0;
    in_blank  = 1'b0;
    out_ready = 1'b1;
    pal_we    = 1'b0;
    pal_addr  = '0;
    pal_data  = '0;
    v4        = 1'b0;
    idx4      = '0;
    for (int i = 0; i < 32; i++) ovr_flag[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_rgb", 32'({rouge, vert, bleu}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Named cube colours, no stall, exact latency; LEVELS=4 corners alongside.
    lat_chk  = 1'b1;
    in_valid = 1'b1;
    v4       = 1'b1;
    in_idx   = 5'd0;  idx4 = 6'd63; tick(1, 8'h00, dummy);
    in_idx   = 5'd13; idx4 = 6'd21; tick(1, 8'h6D, dummy);
    v4       = 1'b0;
    in_idx   = 5'd26; tick(1, 8'hFF, dummy);
    in_idx   = 5'd5;  tick(1, 8'h0F, dummy);
    drain();

    // Out-of-range indices and blanking give black.
    in_valid = 1'b1;
    for (int i = 27; i < 32; i++) begin
      in_idx = 5'(i);
      tick(1, 8'h00, dummy);
    end
    in_idx   = 5'd13;
    in_blank = 1'b1;
    tick(1, 8'h00, dummy);
    in_blank = 1'b0;
    drain();
    lat_chk = 1'b0;

    // Back-to-back 0..26 with a three-cycle downstream stall mid-stream.
    saw_bp = 1'b0;
    begin
      int i, k;
      bit acc;
      i = 0;
      k = 0;
      while (i < 27 && k < 100) begin
        in_valid  = 1'b1;
        in_idx    = 5'(i);
        out_ready = !(k >= 10 && k < 13);
        tick(0, 8'h0, acc);
        if (acc) i++;
        k++;
      end
      check("stream_all_accepted", 32'(i), 32'd27);
    end
    drain();
    check("in_ready_dropped", 32'(saw_bp), 32'd1);

    // Reset with two pixels in flight; nothing stale may appear afterwards.
    in_valid = 1'b1;
    in_idx   = 5'd13; tick(0, 8'h0, dummy);
    in_idx   = 5'd26; tick(0, 8'h0, dummy);
    pulse_reset();
    repeat (4) tick(0, 8'h0, dummy);
    lat_chk  = 1'b1;
    in_valid = 1'b1;
    in_idx   = 5'd5;
    tick(1, 8'h0F, dummy);
    drain();
    lat_chk = 1'b0;

`ifdef PALETTE_WR_EN
    // Same-edge write is invisible to that pixel, visible to the next; reset clears it.
    in_valid = 1'b1;
    in_idx   = 5'd13;
    pal_we   = 1'b1;
    pal_addr = 5'd13;
    pal_data = 8'hE0;
    tick(1, 8'h6D, dummy);
    pal_we = 1'b0;
    tick(1, 8'hE0, dummy);
    drain();
    pulse_reset();
    in_valid = 1'b1;
    in_idx   = 5'd13;
    tick(1, 8'h6D, dummy);
    drain();
`endif

    // Randomised traffic with back-pressure against the model.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_idx    = 5'($urandom_range(0, 31));
      in_blank  = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      pal_we    = PAL_EN && ($urandom_range(0, 15) == 0);
      pal_addr  = 5'($urandom_range(0, 31));
      pal_data  = 8'($urandom_range(0, 255));
      v4        = ($urandom_range(0, 1) != 0);
      idx4      = 6'($urandom_range(0, 63));
      tick(0, 8'h0, dummy);
    end
    in_blank = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
